dram_sort_ctrl: RTL and testbench

In-place bubble-sort engine that sits directly upstream of the 1024×32 distributed-RAM wrapper, driving its `we`/`data`/`addr` inputs and consuming its asynchronous `spo` output. When idle it forwards a host access port straight to the RAM. On `start` it takes over the RAM, sorts words `0..n-1` into ascending order, reports the busy-cycle count, and returns the RAM to the host.

---
 rtl/dram_sort_ctrl_if.sv | 30 +++
 rtl/dram_sort_ctrl.sv | 152 +++++++++++++++
 tb/tb_dram_sort_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_sort_ctrl_if.sv
// Host, control and RAM-side signal bundle for dram_sort_ctrl.
// slave = sort engine view, master = host/RAM side view.
interface dram_sort_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W:0]   n;
    logic              busy;
    logic              done;
    logic [31:0]       cycles;
    logic [ADDR_W-1:0] host_addr;
    logic              host_we;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  start, n, host_addr, host_we, host_wdata, mem_rdata,
        output busy, done, cycles, host_rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output start, n, host_addr, host_we, host_wdata, mem_rdata,
        input  busy, done, cycles, host_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dram_sort_ctrl.sv
// In-place bubble-sort engine in front of an async-read RAM; forwards the host port when idle.
// Define SORT_SIGNED_EN to compare words as two's-complement instead of unsigned.
module dram_sort_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dram_sort_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WR_A, WR_B, DONE} state_t;

    localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              swapped_q, swapped_d;
    logic [31:0]       cycles_q, cycles_d;

    logic [ADDR_W:0]   n_sat;
    logic [ADDR_W:0]   n_m1;
    logic [ADDR_W-1:0] j_inc;
    logic              a_gt;
    logic              busy;
    logic              pair_end;
    logic              pair_swapped;

    assign n_sat = (bus.n > N_MAX) ? N_MAX : bus.n;
    assign n_m1  = n_sat - (ADDR_W+1)'(1);
    assign j_inc = j_q + ADDR_W'(1);
    assign busy  = (state_q == LOAD_A) || (state_q == LOAD_B) ||
                   (state_q == WR_A)   || (state_q == WR_B);

`ifdef SORT_SIGNED_EN
    assign a_gt = $signed(a_q) > $signed(bus.mem_rdata);
`else
    assign a_gt = a_q > bus.mem_rdata;
`endif

    assign bus.busy       = busy;
    assign bus.done       = (state_q == DONE);
    assign bus.cycles     = cycles_q;
    assign bus.host_rdata = bus.mem_rdata;

    always_comb begin
        state_d       = state_q;
        j_d           = j_q;
        last_d        = last_q;
        a_d           = a_q;
        b_d           = b_q;
        swapped_d     = swapped_q;
        cycles_d      = cycles_q;
        bus.mem_addr  = bus.host_addr;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = bus.host_wdata;
        pair_end      = 1'b0;
        pair_swapped  = swapped_q;

        if (busy && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                bus.mem_we = bus.host_we;
                if (bus.start) begin
                    cycles_d = '0;
                    if (n_sat <= (ADDR_W+1)'(1)) begin
                        state_d = DONE;
                    end else begin
                        last_d    = n_m1[ADDR_W-1:0];
                        j_d       = '0;
                        swapped_d = 1'b0;
                        state_d   = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                bus.mem_addr = j_q;
                a_d          = bus.mem_rdata;
                state_d      = LOAD_B;
            end
            LOAD_B: begin
                bus.mem_addr = j_inc;
                if (a_gt) begin
                    b_d       = bus.mem_rdata;
                    swapped_d = 1'b1;
                    state_d   = WR_A;
                end else begin
                    pair_end = 1'b1;
                end
            end
            WR_A: begin
                bus.mem_addr  = j_q;
                bus.mem_wdata = b_q;
                bus.mem_we    = 1'b1;
                state_d       = WR_B;
            end
            WR_B: begin
                bus.mem_addr  = j_inc;
                bus.mem_wdata = a_q;
                bus.mem_we    = 1'b1;
                pair_end      = 1'b1;
                pair_swapped  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pass that swapped nothing means the prefix is sorted; last==1 is the final pass.
        if (pair_end) begin
            if (j_inc < last_q) begin
                j_d     = j_inc;
                state_d = LOAD_A;
            end else if (!pair_swapped || (last_q == ADDR_W'(1))) begin
                state_d = DONE;
            end else begin
                last_d    = last_q - ADDR_W'(1);
                j_d       = '0;
                swapped_d = 1'b0;
                state_d   = LOAD_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            j_q       <= '0;
            last_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            last_q    <= last_d;
            a_q       <= a_d;
            b_q       <= b_d;
            swapped_q <= swapped_d;
            cycles_q  <= cycles_d;
        end
    end
endmodule

// File: tb/tb_dram_sort_ctrl.sv
// Bench for dram_sort_ctrl: RAM model, directed cases, randomized sorts vs. a plain bubble-sort model.
// Honours SORT_SIGNED_EN the same way as the design.
module tb_dram_sort_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    dram_sort_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dram_sort_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:1023];
    logic [31:0] mdl [0:1023];

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = ram[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit gt(input logic [31:0] x, input logic [31:0] y);
`ifdef SORT_SIGNED_EN
        return $signed(x) > $signed(y);
`else
        return x > y;
`endif
    endfunction

    // Reference: bubble sort with early exit, 2 cycles per compared pair plus 2 more per swap.
    task automatic model_sort(input int ns, output int cyc, output int sw);
        int          last;
        bit          pass_sw;
        logic [31:0] t;
        cyc = 0;
        sw  = 0;
        if (ns <= 1) return;
        last = ns - 1;
        forever begin
            pass_sw = 1'b0;
            for (int j = 0; j < last; j++) begin
                if (gt(mdl[j], mdl[j+1])) begin
                    t        = mdl[j];
                    mdl[j]   = mdl[j+1];
                    mdl[j+1] = t;
                    cyc += 4;
                    sw++;
                    pass_sw = 1'b1;
                end else begin
                    cyc += 2;
                end
            end
            if (!pass_sw || last == 1) break;
            last--;
        end
    endtask

    task automatic load_words(input int ns);
        for (int i = 0; i < ns; i++) begin
            bus.host_addr  = 10'(i);
            bus.host_wdata = mdl[i];
            bus.host_we    = 1'b1;
            @(negedge clk);
        end
        bus.host_we = 1'b0;
    endtask

    task automatic read_back(input string tag, input int ns);
        for (int i = 0; i < ns; i++) begin
            bus.host_addr = 10'(i);
            #1;
            check($sformatf("%s_w%0d", tag, i), 64'(bus.host_rdata), 64'(mdl[i]));
        end
    endtask

    task automatic run_sort(input string tag, input int nreq, input bit junk);
        int ns, exp_cyc, exp_sw, bcnt, wcnt;
        bit got;
        ns = (nreq > 1024) ? 1024 : nreq;
        model_sort(ns, exp_cyc, exp_sw);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = 11'(nreq);
        @(negedge clk);
        bus.start = 1'b0;
        if (ns <= 1) begin
            check({tag, "_done"}, 64'(bus.done), 64'd1);
            check({tag, "_busy"}, 64'(bus.busy), 64'd0);
            check({tag, "_cycles"}, 64'(bus.cycles), 64'd0);
            @(negedge clk);
            check({tag, "_done_once"}, 64'(bus.done), 64'd0);
            check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
            $display("txn %s n=%0d cycles=%0d", tag, nreq, bus.cycles);
            return;
        end
        check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
        if (junk) begin
            bus.host_we    = 1'b1;
            bus.host_wdata = 32'hDEAD_BEEF;
        end
        bcnt = 0;
        wcnt = 0;
        got  = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) bcnt++;
            if (bus.busy && bus.mem_we) wcnt++;
            if (junk) bus.host_addr = 10'($urandom_range(0, ns - 1));
            @(negedge clk);
        end
        bus.host_we = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_busy_cnt"}, 64'(bcnt), 64'(exp_cyc));
        check({tag, "_cycles"}, 64'(bus.cycles), 64'(exp_cyc));
        check({tag, "_writes"}, 64'(wcnt), 64'(2 * exp_sw));
        @(negedge clk);
        check({tag, "_done_once"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_cycles_hold"}, 64'(bus.cycles), 64'(exp_cyc));
        read_back(tag, ns);
        $display("txn %s n=%0d cycles=%0d swaps=%0d", tag, nreq, bus.cycles, exp_sw);
    endtask

    initial begin
        n_chk          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.n          = '0;
        bus.host_addr  = '0;
        bus.host_we    = 1'b0;
        bus.host_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_cycles", 64'(bus.cycles), 64'd0);
        bus.host_we = 1'b1;
        #1;
        check("rst_we_follow1", 64'(bus.mem_we), 64'd1);
        bus.host_we = 1'b0;
        #1;
        check("rst_we_follow0", 64'(bus.mem_we), 64'd0);
        $display("txn reset busy=%0d done=%0d cycles=%0d", bus.busy, bus.done, bus.cycles);

        // host pass-through while idle
        mdl[0] = 32'd3; mdl[1] = 32'd1; mdl[2] = 32'd2; mdl[3] = 32'd0;
        @(negedge clk);
        load_words(4);
        read_back("host", 4);
        check("host_busy", 64'(bus.busy), 64'd0);
        $display("txn host_rw words=4");

        mdl[0] = 32'd0; mdl[1] = 32'd1; mdl[2] = 32'd2; mdl[3] = 32'd3;
        load_words(4);
        run_sort("sorted4", 4, 1'b0);
        check("sorted4_const", 64'(bus.cycles), 64'd6);

        mdl[0] = 32'd2; mdl[1] = 32'd1; mdl[2] = 32'd0;
        load_words(3);
        run_sort("rev3", 3, 1'b0);
        check("rev3_const", 64'(bus.cycles), 64'd12);

        mdl[0] = 32'hFFFF_FFFF; mdl[1] = 32'd1;
        load_words(2);
        run_sort("sign2", 2, 1'b0);
`ifdef SORT_SIGNED_EN
        check("sign2_const", 64'(bus.cycles), 64'd2);
`else
        check("sign2_const", 64'(bus.cycles), 64'd4);
`endif

        run_sort("n1", 1, 1'b0);
        run_sort("n0", 0, 1'b0);

        // reset mid-sort, with a second start while busy
        mdl[0] = 32'd3; mdl[1] = 32'd2; mdl[2] = 32'd1; mdl[3] = 32'd0;
        load_words(4);
        bus.start = 1'b1;
        bus.n     = 11'd4;
        @(negedge clk);
        check("rstmid_busy", 64'(bus.busy), 64'd1);
        bus.n = 11'd2;
        @(negedge clk);
        bus.start = 1'b0;
        check("rstmid_busy2", 64'(bus.busy), 64'd1);
        check("rstmid_cycles", 64'(bus.cycles), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_idle", 64'(bus.busy), 64'd0);
        check("rstmid_cycles0", 64'(bus.cycles), 64'd0);
        check("rstmid_nodone", 64'(bus.done), 64'd0);
        bus.host_addr  = 10'd0;
        bus.host_wdata = 32'h0000_0055;
        bus.host_we    = 1'b1;
        @(negedge clk);
        bus.host_we = 1'b0;
        #1;
        check("rstmid_hostwr", 64'(bus.host_rdata), 64'h55);
        $display("txn rst_midsort busy=%0d cycles=%0d", bus.busy, bus.cycles);

        for (int t = 0; t < 6; t++) begin
            int ns;
            ns = $urandom_range(2, 16);
            for (int i = 0; i < ns; i++) begin
                mdl[i] = (t % 2 == 0) ? $urandom : 32'($urandom_range(0, 7));
            end
            @(negedge clk);
            load_words(ns);
            run_sort($sformatf("rand%0d", t), ns, 1'b1);
        end

        // n beyond the RAM size saturates to the full 1024 words
        for (int i = 0; i < 1024; i++) mdl[i] = 32'(i);
        @(negedge clk);
        load_words(1024);
        run_sort("sat", 1500, 1'b0);
        check("sat_const", 64'(bus.cycles), 64'd2046);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
